data_axi_bridge: RTL and testbench
==================================

Name: data_axi_bridge

Overview:
- Sits directly downstream of the MEM stage on the data-memory path.
- Accepts one load/store request at a time from MEM_stage using its data_ready / rdata_valid handshake.
- Converts each request into a single-beat AXI read (AR/R) or write (AW/W/B) transaction.
- Returns load data to MEM_stage; holds data_ready low until the current transaction retires.

Parameters:
- AXI_ID, 4'd1: constant arid/awid/wid value driven on all transactions.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous assert, active-low
- mem_req  in  1  request valid from MEM (MemRead_o | (|MemWrite_o))
- mem_wr  in  1  1=store, 0=load
- mem_size  in  2  0=byte, 1=half, 2=word
- mem_addr  in  32  byte address
- mem_wstrb  in  4  byte enables (store only)
- mem_wdata  in  32  store data, already lane-aligned
- data_ready  out  1  bridge idle; request accepted when mem_req & data_ready
- rdata_valid  out  1  one-cycle pulse; rdata valid for the load
- rdata  out  32  raw load word
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1;  arready  in  1
- rid/rdata_axi/rresp/rlast/rvalid  in  4/32/2/1/1;  rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1;  awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1;  wready  in  1
- bid/bresp/bvalid  in  4/2/1;  bready  out  1

Behaviour:
- Asynchronous reset (resetn=0): state=IDLE.
  - All valid/ready outputs 0 except data_ready=1.
  - rdata=0, latched address/data=0.
  - Applies immediately, even mid-transaction; any in-flight AXI transaction is abandoned.
- Constant AXI fields: arlen=awlen=0, arburst=awburst=2'b01, wlast=1, arsize=awsize={1'b0,mem_size} as latched.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - data_ready=1.
  - On mem_req: latch addr, size, wstrb, wdata.
  - mem_wr=0 -> RD_ADDR; mem_wr=1 -> WR_REQ with both awvalid and wvalid set.
- RD_ADDR: arvalid=1; on arready -> RD_DATA; arvalid drops the next cycle.
- RD_DATA:
  - rready=1.
  - On rvalid: register rdata_axi into rdata, pulse rdata_valid next cycle, -> IDLE.
  - rresp is ignored (no bus-error exception path).
- WR_REQ:
  - awvalid and wvalid are cleared independently on their own handshakes.
  - Both may complete in the same cycle or in different cycles, in either order.
  - -> WR_RESP once both have handshaked.
- WR_RESP: bready=1; on bvalid -> IDLE. No rdata_valid is generated for stores.
- data_ready is 0 in every state except IDLE; mem_req while busy is not accepted and the requester holds it.
- Minimum load latency with arready=rvalid=1 throughout:
  - accept at cycle 0, arvalid at cycle 1, rready/rvalid at cycle 2, rdata_valid at cycle 3.
- Minimum store latency: awvalid/wvalid at cycle 1, bvalid at cycle 2, data_ready=1 again at cycle 3.
- rdata holds its value until the next load completes.
- Outputs are registered from state; no combinational path from AXI inputs to AXI valid outputs.

Optional Feature:
DATA_BRIDGE_WBUF_EN
- Defined:
  - Adds a 2-entry posted write buffer.
  - A store is accepted in IDLE or while buffer not full; data_ready for stores returns 1 the cycle after acceptance.
  - Buffer drains in order through WR_REQ/WR_RESP.
  - A load is accepted only when the buffer is empty (data_ready=0 otherwise), preserving read-after-write ordering.
  - Full buffer forces data_ready=0.
- Undefined: no buffer; behaviour exactly as above.

Decomposition:
- Shared package:
  - state encoding for the five states
  - AXI constants: BURST_INCR=2'b01, LEN_SINGLE=8'd0, SIZE_B/H/W
- Sub-module data_bridge_wbuf: 2-entry FIFO of {addr, size, wstrb, wdata}; instantiated only under DATA_BRIDGE_WBUF_EN.

Test Plan:
- Load, zero-wait slave: mem_addr=0x1000, rdata_axi=0xDEADBEEF -> araddr=0x1000, arsize=2, rdata_valid at cycle 3, rdata=0xDEADBEEF, data_ready=1 at cycle 3.
- Load, arready delayed 3 cycles and rvalid delayed 2 cycles -> arvalid held for 4 cycles, single rdata_valid pulse, data_ready=0 throughout.
- Store with wready before awready (wready cycle 1, awready cycle 3), mem_wstrb=4'b0011, mem_wdata=0x0000ABCD -> wvalid drops after cycle 1, awvalid after cycle 3; bready asserted; no rdata_valid.
- Back-to-back requests: mem_req held high across a load then a store -> second request is latched only on the IDLE cycle, with correct awaddr.
- resetn deasserted mid RD_DATA -> all valid outputs 0 and data_ready=1 immediately (asynchronously); no rdata_valid after release.
- With DATA_BRIDGE_WBUF_EN: two stores then a load, bvalid delayed -> both stores accepted, load stalls until buffer empty, then ar issues.

Source files
------------

// File: rtl/data_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_axi_bridge_pkg
// Description : Shared definitions for the MEM-stage to AXI data bridge:
//               FSM state encoding and the fixed AXI field values.
// Revision    : 1.0 - initial release
// ============================================================================
package data_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } bridge_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;
    localparam logic [2:0] SIZE_B     = 3'd0;
    localparam logic [2:0] SIZE_H     = 3'd1;
    localparam logic [2:0] SIZE_W     = 3'd2;

    // MEM size code to AXI AxSIZE; the reserved code 3 passes straight through.
    function automatic logic [2:0] axi_size(input logic [1:0] i_size);
        case (i_size)
            2'd0:    axi_size = SIZE_B;
            2'd1:    axi_size = SIZE_H;
            2'd2:    axi_size = SIZE_W;
            default: axi_size = {1'b0, i_size};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_axi_bridge_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : data_bridge_wbuf
// Description : Two-entry in-order FIFO holding posted stores
//               {addr, size, wstrb, wdata} for the data AXI bridge.
// Ports       : clk, rst_n (async, active-low)
//               i_push + i_addr/i_size/i_wstrb/i_wdata : enqueue
//               i_pop                                  : dequeue head
//               o_addr/o_size/o_wstrb/o_wdata           : head entry
//               o_full / o_empty                       : occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module data_bridge_wbuf
    import data_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [1:0]            i_size,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_pop,
    output logic [ADDR_W-1:0]     o_addr,
    output logic [1:0]            o_size,
    output logic [DATA_W/8-1:0]   o_wstrb,
    output logic [DATA_W-1:0]     o_wdata,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int ENTRY_W = ADDR_W + 2 + DATA_W/8 + DATA_W;

    logic [ENTRY_W-1:0] r_mem [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= {i_addr, i_size, i_wstrb, i_wdata};
                r_wptr        <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign {o_addr, o_size, o_wstrb, o_wdata} = r_mem[r_rptr];

endmodule
`default_nettype wire

// File: rtl/data_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : data_axi_bridge
// Description : Converts single MEM-stage load/store requests into
//               single-beat AXI read (AR/R) or write (AW/W/B) transactions.
//               Optional macro DATA_BRIDGE_WBUF_EN adds a 2-entry posted
//               write buffer (data_bridge_wbuf).
// Ports       : clk, resetn (async assert, active-low)
//               MEM side : mem_req/mem_wr/mem_size/mem_addr/mem_wstrb/
//                          mem_wdata in; data_ready/rdata_valid/rdata out
//               AXI side : AR, R, AW, W, B channels (AXI3 style, with wid)
// Revision    : 1.0 - initial release
// ============================================================================
module data_axi_bridge
    import data_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    // MEM stage side
    input  logic                  mem_req,
    input  logic                  mem_wr,
    input  logic [1:0]            mem_size,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic                  data_ready,
    output logic                  rdata_valid,
    output logic [DATA_W-1:0]     rdata,
    // AR channel
    output logic [3:0]            arid,
    output logic [ADDR_W-1:0]     araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    // R channel
    input  logic [3:0]            rid,
    input  logic [DATA_W-1:0]     rdata_axi,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    // AW channel
    output logic [3:0]            awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    // W channel
    output logic [3:0]            wid,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    // B channel
    input  logic [3:0]            bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    bridge_state_t          r_state;
    bridge_state_t          w_state_nxt;

    logic [ADDR_W-1:0]      r_addr;
    logic [1:0]             r_size;
    logic [DATA_W/8-1:0]    r_wstrb;
    logic [DATA_W-1:0]      r_wdata;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_rdata_valid;

    logic                   w_idle;
    logic                   w_start_rd;
    logic                   w_start_wr;
    logic [ADDR_W-1:0]      w_src_addr;
    logic [1:0]             w_src_size;
    logic [DATA_W/8-1:0]    w_src_wstrb;
    logic [DATA_W-1:0]      w_src_wdata;
    logic                   w_aw_done;
    logic                   w_w_done;

    assign w_idle = (r_state == ST_IDLE);

`ifdef DATA_BRIDGE_WBUF_EN
    // Stores are posted into the buffer; the FSM drains it whenever idle.
    // Loads wait for an empty buffer so they never overtake a pending store.
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic [ADDR_W-1:0]      w_buf_addr;
    logic [1:0]             w_buf_size;
    logic [DATA_W/8-1:0]    w_buf_wstrb;
    logic [DATA_W-1:0]      w_buf_wdata;

    assign w_push     = mem_req & mem_wr & ~w_full;
    assign w_start_wr = w_idle & ~w_empty;
    assign w_start_rd = w_idle & w_empty & mem_req & ~mem_wr;
    assign data_ready = mem_wr ? ~w_full : (w_idle & w_empty);

    data_bridge_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk     (clk),
        .rst_n   (resetn),
        .i_push  (w_push),
        .i_addr  (mem_addr),
        .i_size  (mem_size),
        .i_wstrb (mem_wstrb),
        .i_wdata (mem_wdata),
        .i_pop   (w_start_wr),
        .o_addr  (w_buf_addr),
        .o_size  (w_buf_size),
        .o_wstrb (w_buf_wstrb),
        .o_wdata (w_buf_wdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_src_addr  = w_start_wr ? w_buf_addr  : mem_addr;
    assign w_src_size  = w_start_wr ? w_buf_size  : mem_size;
    assign w_src_wstrb = w_start_wr ? w_buf_wstrb : mem_wstrb;
    assign w_src_wdata = w_start_wr ? w_buf_wdata : mem_wdata;
`else
    assign data_ready  = w_idle;
    assign w_start_rd  = w_idle & mem_req & ~mem_wr;
    assign w_start_wr  = w_idle & mem_req & mem_wr;
    assign w_src_addr  = mem_addr;
    assign w_src_size  = mem_size;
    assign w_src_wstrb = mem_wstrb;
    assign w_src_wdata = mem_wdata;
`endif

    // A write channel counts as done if it already handshook or does so now.
    assign w_aw_done = ~r_awvalid | awready;
    assign w_w_done  = ~r_wvalid  | wready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rd) begin
                    w_state_nxt = ST_RD_ADDR;
                end else if (w_start_wr) begin
                    w_state_nxt = ST_WR_REQ;
                end
            end
            ST_RD_ADDR: begin
                if (arready) begin
                    w_state_nxt = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (w_aw_done && w_w_done) begin
                    w_state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr        <= '0;
            r_size        <= 2'd0;
            r_wstrb       <= '0;
            r_wdata       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            if (w_start_rd || w_start_wr) begin
                r_addr  <= w_src_addr;
                r_size  <= w_src_size;
                r_wstrb <= w_src_wstrb;
                r_wdata <= w_src_wdata;
            end
            if (w_start_wr) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
            end else if (r_state == ST_WR_REQ) begin
                if (awready) begin
                    r_awvalid <= 1'b0;
                end
                if (wready) begin
                    r_wvalid <= 1'b0;
                end
            end
            // rresp is deliberately ignored: there is no bus-error path.
            if ((r_state == ST_RD_DATA) && rvalid) begin
                r_rdata       <= rdata_axi;
                r_rdata_valid <= 1'b1;
            end
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;

    assign arid    = AXI_ID;
    assign araddr  = r_addr;
    assign arlen   = LEN_SINGLE;
    assign arsize  = axi_size(r_size);
    assign arburst = BURST_INCR;
    assign arvalid = (r_state == ST_RD_ADDR);
    assign rready  = (r_state == ST_RD_DATA);

    assign awid    = AXI_ID;
    assign awaddr  = r_addr;
    assign awlen   = LEN_SINGLE;
    assign awsize  = axi_size(r_size);
    assign awburst = BURST_INCR;
    assign awvalid = r_awvalid;

    assign wid     = AXI_ID;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;
    assign wvalid  = r_wvalid;

    assign bready  = (r_state == ST_WR_RESP);

    // Response IDs and status are not needed with a single outstanding beat.
    logic w_unused;
    assign w_unused = &{1'b0, rid, rresp, rlast, bid, bresp};

endmodule
`default_nettype wire

// File: tb/tb_data_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_axi_bridge
// Description : Directed plus randomized bench for data_axi_bridge with a
//               cycle-level slave and a transaction-level expectation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_axi_bridge;

    localparam logic [3:0] C_ID = 4'd1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        data_ready, rdata_valid;
    logic [31:0] rdata;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata_axi;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdata;
    logic [31:0] t_addr, t_data;
    logic [3:0]  t_strb;
    logic [1:0]  t_size;

    always #5 clk = ~clk;

    data_axi_bridge #(.AXI_ID(C_ID), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .data_ready(data_ready), .rdata_valid(rdata_valid), .rdata(rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Load: accept now, slave raises arready after ard waiting cycles and
    // rvalid after rd waiting cycles. Returns at the rdata_valid cycle.
    // With pend set, mem_req stays high carrying a store to paddr.
    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input int ard,
                           input int rd, input logic [31:0] data, input bit pend,
                           input logic [31:0] paddr);
        mem_req = 1'b1; mem_wr = 1'b0; mem_addr = addr; mem_size = size;
        mem_wstrb = 4'($urandom); mem_wdata = $urandom;
        check("ld_accept_ready", data_ready, 1'b1);
        @(negedge clk);
        if (pend) begin
            mem_wr = 1'b1; mem_addr = paddr;
        end else begin
            mem_req = 1'b0;
        end
        for (int k = 0; k <= ard; k++) begin
            check("ld_arvalid", arvalid, 1'b1);
            check("ld_araddr", araddr, addr);
            check("ld_arsize", arsize, {1'b0, size});
            check("ld_busy_ar", data_ready, 1'b0);
            check("ld_no_aw", awvalid, 1'b0);
            check("ld_no_rvld_ar", rdata_valid, 1'b0);
            check("ld_rdata_hold", rdata, exp_rdata);
            if (k == 0) begin
                check("ld_arid", arid, C_ID);
                check("ld_arlen", arlen, 8'd0);
                check("ld_arburst", arburst, 2'b01);
                check("ld_rready_low", rready, 1'b0);
            end
            arready = (k == ard);
            @(negedge clk);
        end
        arready = 1'b0;
        for (int k = 0; k <= rd; k++) begin
            check("ld_rready", rready, 1'b1);
            check("ld_arvalid_drop", arvalid, 1'b0);
            check("ld_busy_r", data_ready, 1'b0);
            check("ld_no_rvld_r", rdata_valid, 1'b0);
            rvalid    = (k == rd);
            rdata_axi = (k == rd) ? data : $urandom;
            @(negedge clk);
        end
        rvalid = 1'b0;
        exp_rdata = data;
        check("ld_rdata_valid", rdata_valid, 1'b1);
        check("ld_rdata", rdata, exp_rdata);
        check("ld_ready_again", data_ready, 1'b1);
        check("ld_rready_drop", rready, 1'b0);
    endtask

    // Store: awready after awd waits, wready after wd waits, bvalid after bd
    // waits. Returns at the first idle cycle after the response.
    task automatic do_store(input logic [31:0] addr, input logic [1:0] size,
                            input logic [3:0] strb, input logic [31:0] data,
                            input int awd, input int wd, input int bd);
        int n;
        n = (awd > wd) ? awd : wd;
        mem_req = 1'b1; mem_wr = 1'b1; mem_addr = addr; mem_size = size;
        mem_wstrb = strb; mem_wdata = data;
        check("st_accept_ready", data_ready, 1'b1);
        @(negedge clk);
        mem_req = 1'b0;
        for (int k = 0; k <= n; k++) begin
            check("st_awvalid", awvalid, (k <= awd));
            check("st_wvalid", wvalid, (k <= wd));
            if (k <= awd) begin
                check("st_awaddr", awaddr, addr);
                check("st_awsize", awsize, {1'b0, size});
            end
            if (k <= wd) begin
                check("st_wdata", wdata, data);
                check("st_wstrb", wstrb, strb);
            end
            check("st_busy_req", data_ready, 1'b0);
            check("st_bready_low", bready, 1'b0);
            check("st_no_rvld", rdata_valid, 1'b0);
            check("st_no_ar", arvalid, 1'b0);
            if (k == 0) begin
                check("st_awid", awid, C_ID);
                check("st_wid", wid, C_ID);
                check("st_awlen", awlen, 8'd0);
                check("st_awburst", awburst, 2'b01);
                check("st_wlast", wlast, 1'b1);
            end
            awready = (k == awd);
            wready  = (k == wd);
            @(negedge clk);
        end
        awready = 1'b0; wready = 1'b0;
        for (int k = 0; k <= bd; k++) begin
            check("st_bready", bready, 1'b1);
            check("st_aw_clear", awvalid, 1'b0);
            check("st_w_clear", wvalid, 1'b0);
            check("st_busy_resp", data_ready, 1'b0);
            check("st_no_rvld_b", rdata_valid, 1'b0);
            bvalid = (k == bd);
            @(negedge clk);
        end
        bvalid = 1'b0;
        check("st_ready_again", data_ready, 1'b1);
        check("st_bready_drop", bready, 1'b0);
        check("st_no_rvld_end", rdata_valid, 1'b0);
        check("st_rdata_hold", rdata, exp_rdata);
    endtask

    initial begin
        resetn = 1'b0; exp_rdata = 32'd0;
        mem_req = 1'b0; mem_wr = 1'b0; mem_size = 2'd0; mem_addr = 32'd0;
        mem_wstrb = 4'd0; mem_wdata = 32'd0;
        arready = 1'b0; rid = C_ID; rdata_axi = 32'd0; rresp = 2'd0; rlast = 1'b1;
        rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bid = C_ID; bresp = 2'd0;
        bvalid = 1'b0;
        @(negedge clk); @(negedge clk);

        // Reset state
        check("rst_data_ready", data_ready, 1'b1);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_rdata_valid", rdata_valid, 1'b0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_araddr", araddr, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Zero-wait load
        do_load(32'h1000, 2'd2, 0, 0, 32'hDEADBEEF, 1'b0, 32'd0);
        // Delayed arready (3) and rvalid (2)
        do_load(32'h1004, 2'd1, 3, 2, 32'h12345678, 1'b0, 32'd0);
        // Store, wready at cycle 1 and awready at cycle 3
        do_store(32'h2000, 2'd1, 4'b0011, 32'h0000ABCD, 2, 0, 1);
        // Store, awready before wready
        do_store(32'h2004, 2'd0, 4'b0100, 32'h00EF0000, 0, 2, 0);
        // Back-to-back: store held on mem_req during a load
        do_load(32'h3000, 2'd2, 1, 1, 32'hCAFEF00D, 1'b1, 32'h3008);
        do_store(32'h3008, 2'd2, 4'b1111, 32'h55AA55AA, 0, 0, 0);

        // Reset asserted in RD_DATA
        mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h4000; mem_size = 2'd2;
        @(negedge clk);
        mem_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("mid_rready", rready, 1'b1);
        #2 resetn = 1'b0;
        #1;
        exp_rdata = 32'd0;
        check("arst_data_ready", data_ready, 1'b1);
        check("arst_rready", rready, 1'b0);
        check("arst_arvalid", arvalid, 1'b0);
        check("arst_awvalid", awvalid, 1'b0);
        check("arst_wvalid", wvalid, 1'b0);
        check("arst_bready", bready, 1'b0);
        check("arst_rdata", rdata, exp_rdata);
        @(negedge clk);
        resetn = 1'b1; rvalid = 1'b1; rdata_axi = 32'hBADBAD00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_no_rvld", rdata_valid, 1'b0);
            check("post_rst_rready", rready, 1'b0);
            check("post_rst_ready", data_ready, 1'b1);
        end
        rvalid = 1'b0;

        // Randomized mix
        for (int i = 0; i < 24; i++) begin
            t_addr = $urandom; t_data = $urandom; t_strb = 4'($urandom);
            t_size = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) begin
                do_load(t_addr, t_size, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        t_data, 1'b0, 32'd0);
            end else begin
                do_store(t_addr, t_size, t_strb, t_data, int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
        end
        @(negedge clk);
        check("final_no_rvld", rdata_valid, 1'b0);
        check("final_rdata", rdata, exp_rdata);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
